uartrx: RTL and testbench

//   UART receiver, 8N1, LSB first. Counterpart of the on-chip UART transmitter
//   and shares its go/busy-style handshake. Oversamples the async rx pin with
//   the system clock, samples each bit at mid-bit, and presents a complete byte

---
 rtl/uart_pkg.sv | 19 +
 rtl/uartrx_if.sv | 28 ++
 rtl/uartrx_sync_2ff.sv | 25 ++
 rtl/uartrx.sv | 147 ++++++++++++++
 tb/tb_uartrx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding used by both the transmitter
// and the receiver, plus the bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
        StopBit,
        WaitForGoLow
    } state_e;

    // Clocks per bit period, integer floor.
    function automatic int unsigned bit_time(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uartrx_if.sv
// Consumer-side bundle of the UART receiver.
//
// Handshake (go/busy style, shared with the transmitter): the consumer holds
// go high to arm the receiver. When a frame completes, data_ready rises and
// data/framing_error are stable. They are held until the consumer drops go.
// data_ready falls on the clock after go is seen low. Dropping go while a
// frame is in flight aborts that frame without touching the outputs.
interface uartrx_if;
    import uart_pkg::*;

    logic       rx;
    logic       go;
    logic [7:0] data;
    logic       data_ready;
    logic       framing_error;
    state_e     state;

    modport master (
        output rx, go,
        input  data, data_ready, framing_error, state
    );

    modport slave (
        input  rx, go,
        output data, data_ready, framing_error, state
    );

endinterface

// File: rtl/uartrx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so an idle-high line does not look active out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uartrx.sv
// UART receiver, 8N1, LSB first. Samples each bit at mid-bit using a
// countdown timer, and holds the completed byte until go drops.
module uartrx
    import uart_pkg::*;
#(
    parameter int unsigned ClockFrequencyHz = 66_000_000,
    parameter int unsigned BaudRate         = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    uartrx_if.slave   bus
);

    localparam int unsigned BIT_TIME = bit_time(ClockFrequencyHz, BaudRate);
    localparam int          CW       = $clog2(BIT_TIME);

    // First sample of a frame lands half a bit after the start edge;
    // every later sample is one full bit after the previous one.
    localparam logic [CW-1:0] HALF_RELOAD = CW'(BIT_TIME / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(BIT_TIME - 1);

    generate
        if (BIT_TIME < 4) begin : g_bit_time_check
            $error("uartrx: BIT_TIME must be at least 4 clocks per bit");
        end
    endgenerate

    logic          rx_s;
    state_e        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    data_r, data_next;
    logic          ready_r, ready_next;
    logic          fe_r, fe_next;

    sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // Next-state and datapath decisions; every target defaults to hold.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        data_next    = data_r;
        ready_next   = ready_r;
        fe_next      = fe_r;

        case (state)
            Idle: begin
                if (bus.go && !rx_s) begin
                    state_next = StartBit;
                    cnt_next   = HALF_RELOAD;
                end
            end

            StartBit: begin
                if (!bus.go) begin
                    state_next = Idle;
                end else if (cnt == '0) begin
                    // A start bit that is no longer low at mid-bit was a glitch.
                    if (!rx_s) begin
                        state_next   = DataBits;
                        cnt_next     = FULL_RELOAD;
                        bit_cnt_next = 4'd0;
                    end else begin
                        state_next = Idle;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            DataBits: begin
                if (!bus.go) begin
                    state_next = Idle;
                end else if (cnt == '0) begin
                    shift_next[bit_cnt[2:0]] = rx_s;
                    bit_cnt_next             = bit_cnt + 1'b1;
                    cnt_next                 = FULL_RELOAD;
                    if (bit_cnt == 4'd7) begin
                        state_next = StopBit;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            StopBit: begin
                if (!bus.go) begin
                    state_next = Idle;
                end else if (cnt == '0) begin
                    data_next  = shift_reg;
                    fe_next    = !rx_s;
                    ready_next = 1'b1;
                    state_next = WaitForGoLow;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            WaitForGoLow: begin
                // Line activity here is ignored until the consumer acks.
                if (!bus.go) begin
                    state_next = Idle;
                    ready_next = 1'b0;
                end
            end

            default: begin
                state_next = Idle;
            end
        endcase
    end

    // Single register stage for FSM and datapath; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= Idle;
            cnt       <= '0;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            data_r    <= 8'h00;
            ready_r   <= 1'b0;
            fe_r      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            data_r    <= data_next;
            ready_r   <= ready_next;
            fe_r      <= fe_next;
        end
    end

    assign bus.data          = data_r;
    assign bus.data_ready    = ready_r;
    assign bus.framing_error = fe_r;
    assign bus.state         = state;

endmodule

// File: tb/tb_uartrx.sv
// Directed bench for uartrx at 10 clocks per bit. Expected bytes are queued
// as frames are driven and popped when data_ready rises.
module tb_uartrx;
    import uart_pkg::*;

    localparam int BT = 10;

    logic clk;
    logic rst_n;
    uartrx_if bus ();

    uartrx #(.ClockFrequencyHz(10), .BaudRate(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Scoreboard state
    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int start_cycle = 0;
    int rise_cycle = 0;
    logic ready_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Driver: one 8N1 frame, LSB first, BT clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cycle = cycle_cnt;
        bus.rx = 1'b0;
        tick(BT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(BT);
        end
        bus.rx = stop_bit;
        tick(BT);
        bus.rx = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.data_ready !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        assert (bus.data_ready === 1'b1) else begin
            errors++;
            $error("FAIL %s: data_ready got %b expected 1 within 300 clk", tag, bus.data_ready);
        end
    endtask

    task automatic ack(input string tag);
        bus.go = 1'b0;
        tick(1);
        chk({tag, "_ready_low"}, 32'(bus.data_ready), 32'd0);
        tick(2);
        bus.go = 1'b1;
    endtask

    // Monitor: each rising data_ready must match the oldest expected byte.
    always @(negedge clk) begin
        logic [8:0] e;
        if (bus.data_ready === 1'b1 && ready_q !== 1'b1) begin
            rise_cycle = cycle_cnt;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_byte: got data %0h fe %b expected none", bus.data, bus.framing_error);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(bus.data), 32'(e[7:0]));
                chk("sb_fe", 32'(bus.framing_error), 32'(e[8]));
            end
        end
        ready_q = bus.data_ready;
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        bus.rx = 1'b1;
        bus.go = 1'b0;
        tick(3);
        chk("rst_data", 32'(bus.data), 32'h00);
        chk("rst_ready", 32'(bus.data_ready), 32'd0);
        chk("rst_fe", 32'(bus.framing_error), 32'd0);
        chk("rst_state", 32'(bus.state), 32'(Idle));
        rst_n = 1'b1;
        tick(3);

        // 1: basic byte, latency, hold until ack
        bus.go = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1);
        wait_ready("t1_ready");
        lat = rise_cycle - start_cycle;
        checks++;
        assert (lat >= 97 && lat <= 99) else begin
            errors++;
            $error("FAIL t1_latency: got %0d expected 98+/-1", lat);
        end
        tick(50);
        chk("t1_hold_ready", 32'(bus.data_ready), 32'd1);
        chk("t1_hold_data", 32'(bus.data), 32'hA5);
        ack("t1");

        // 2: short low glitch is rejected, next byte still good
        bus.rx = 1'b0;
        tick(3);
        bus.rx = 1'b1;
        tick(20);
        chk("t2_state", 32'(bus.state), 32'(Idle));
        chk("t2_ready", 32'(bus.data_ready), 32'd0);
        exp_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1);
        wait_ready("t2_ready_5a");
        ack("t2");

        // 3: bad stop bit flags framing error; next good byte clears it
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0);
        wait_ready("t3_ready_3c");
        ack("t3a");
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1);
        wait_ready("t3_ready_c3");
        ack("t3b");

        // 4: abort mid-frame by dropping go
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1);
        wait_ready("t4_ready_a5");
        ack("t4a");
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(45);
                bus.go = 1'b0;
            end
        join
        chk("t4_abort_state", 32'(bus.state), 32'(Idle));
        chk("t4_abort_data", 32'(bus.data), 32'hA5);
        chk("t4_abort_ready", 32'(bus.data_ready), 32'd0);
        bus.go = 1'b1;
        tick(2);
        exp_q.push_back({1'b0, 8'h0F});
        send_frame(8'h0F, 1'b1);
        wait_ready("t4_ready_0f");
        ack("t4b");

        // 5: reset mid-DataBits, then two back-to-back bytes
        fork
            send_frame(8'h55, 1'b1);
            begin
                tick(40);
                bus.go = 1'b0;
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
                chk("t5_rst_data", 32'(bus.data), 32'h00);
                chk("t5_rst_ready", 32'(bus.data_ready), 32'd0);
                chk("t5_rst_fe", 32'(bus.framing_error), 32'd0);
                chk("t5_rst_state", 32'(bus.state), 32'(Idle));
            end
        join
        tick(2);
        bus.go = 1'b1;
        exp_q.push_back({1'b0, 8'h00});
        send_frame(8'h00, 1'b1);
        wait_ready("t5_ready_00");
        bus.go = 1'b0;
        tick(1);
        chk("t5_b2b_ready_low", 32'(bus.data_ready), 32'd0);
        bus.go = 1'b1;
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'hFF, 1'b1);
        wait_ready("t5_ready_ff");
        ack("t5");

        // 6: break (line held low past a full frame)
        exp_q.push_back({1'b1, 8'h00});
        bus.rx = 1'b0;
        tick(120);
        bus.rx = 1'b1;
        wait_ready("t6_ready_break");
        tick(5);
        ack("t6a");
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1);
        wait_ready("t6_ready_81");
        ack("t6b");

        tick(5);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_state", 32'(bus.state), 32'(Idle));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
